// File: rtl/sp_ram_param.sv
// sp_ram_param: byte-enabled single-port RAM with post-reset clear sequencer; define SPRAM_OUTREG_EN for a second output register stage
module sp_ram_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int RW_MODE = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  output logic                o_busy
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word, merged, mem_wdata, s1_data;
  logic [ADDR_W-1:0] mem_addr;
  logic acc, mem_we, s1_valid, s1_load;
  assign old_word = mem[i_addr];
  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign merged[8*b +: 8] = i_be[b] ? i_data[8*b +: 8] : old_word[8*b +: 8];
  end
  // the clear sequencer and accepted writes share the single memory port; reset blocks both
  always_comb begin
    acc = state == READY && i_ce;
    s1_load = acc && (!i_we || RW_MODE != 2);
    mem_we = !i_reset && (state == CLEAR || (acc && i_we));
    mem_addr = state == CLEAR ? clr_ptr : i_addr;
    mem_wdata = state == CLEAR ? '0 : merged;
  end
  // storage array, no reset: contents are zeroed by the clear sequencer
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  // clear/ready controller with the first output register stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      clr_ptr <= '0;
      o_busy <= 1'b1;
      s1_data <= '0;
      s1_valid <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      s1_valid <= 1'b0;
      if (clr_ptr == LAST) begin
        state <= READY;
        o_busy <= 1'b0;
      end
    end else begin
      s1_valid <= s1_load;
      if (s1_load) s1_data <= (i_we && RW_MODE == 1) ? merged : old_word;
    end
  end
`ifdef SPRAM_OUTREG_EN
  logic [DATA_W-1:0] s2_data;
  logic s2_valid;
  // second output stage: data only advances when stage one carries a new word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_data <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end
  assign o_data = s2_data;
  assign o_valid = s2_valid;
`else
  assign o_data = s1_data;
  assign o_valid = s1_valid;
`endif
endmodule

// File: tb/tb_sp_ram_param.sv
// tb_sp_ram_param: table-driven check of sp_ram_param in all three read-during-write modes
module tb_sp_ram_param;
`ifdef SPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk, reset, ce, we;
  logic [3:0] be, addr;
  logic [31:0] data, d0, d1, d2;
  logic v0, v1, v2, bz0, bz1, bz2;
  int errors = 0, checks = 0;
  typedef struct {
    logic ce, we;
    logic [3:0] be, addr;
    logic [31:0] data, e0, e1, e2;
    logic ev0, ev1, ev2;
  } vec_t;
  vec_t tv [14];
  sp_ram_param #(.DATA_W(32), .ADDR_W(4), .RW_MODE(0)) u0 (.i_clk(clk), .i_reset(reset), .i_ce(ce), .i_we(we), .i_be(be), .i_addr(addr), .i_data(data), .o_data(d0), .o_valid(v0), .o_busy(bz0));
  sp_ram_param #(.DATA_W(32), .ADDR_W(4), .RW_MODE(1)) u1 (.i_clk(clk), .i_reset(reset), .i_ce(ce), .i_we(we), .i_be(be), .i_addr(addr), .i_data(data), .o_data(d1), .o_valid(v1), .o_busy(bz1));
  sp_ram_param #(.DATA_W(32), .ADDR_W(4), .RW_MODE(2)) u2 (.i_clk(clk), .i_reset(reset), .i_ce(ce), .i_we(we), .i_be(be), .i_addr(addr), .i_data(data), .o_data(d2), .o_valid(v2), .o_busy(bz2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic busy_window(input string nm);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s busy c%0d", nm, k), {bz0, bz1, bz2}, 3'b111);
      chk($sformatf("%s valid c%0d", nm, k), {v0, v1, v2}, 3'b000);
      step();
    end
    chk($sformatf("%s busy done", nm), {bz0, bz1, bz2}, 3'b000);
  endtask
  task automatic stream(input logic wr, input logic zero);
    for (int c = 0; c < 16 + LAT; c++) begin
      int r;
      logic [31:0] e;
      if (c < 16) begin
        ce = 1'b1;
        we = wr;
        be = 4'hF;
        addr = c[3:0];
        data = 32'(c) * 32'h01010101;
      end else begin
        ce = 1'b0;
        we = 1'b0;
      end
      step();
      r = c - LAT + 1;
      e = zero ? 32'h0 : 32'(r) * 32'h01010101;
      if (r >= 0 && r < 16) begin
        chk($sformatf("stream wr=%0d r%0d valid", wr, r), wr ? v1 : v0, 1'b1);
        chk($sformatf("stream wr=%0d r%0d data", wr, r), wr ? d1 : d0, e);
      end else if (r == 16) begin
        chk($sformatf("stream wr=%0d tail valid", wr), wr ? v1 : v0, 1'b0);
      end
    end
  endtask
  initial begin
    tv[0]  = '{1, 1, 4'hF, 4'd3,  32'hAABBCCDD, 32'h00000000, 32'hAABBCCDD, 32'h00000000, 1, 1, 0};
    tv[1]  = '{1, 1, 4'h5, 4'd3,  32'h11223344, 32'hAABBCCDD, 32'hAA22CC44, 32'h00000000, 1, 1, 0};
    tv[2]  = '{1, 0, 4'h0, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 1, 1};
    tv[3]  = '{1, 1, 4'hF, 4'd7,  32'h12345678, 32'h00000000, 32'h12345678, 32'hAA22CC44, 1, 1, 0};
    tv[4]  = '{1, 1, 4'hF, 4'd7,  32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'hAA22CC44, 1, 1, 0};
    tv[5]  = '{1, 0, 4'h0, 4'd7,  32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1};
    tv[6]  = '{0, 0, 4'h0, 4'd3,  32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0};
    tv[7]  = '{1, 0, 4'h0, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 1, 1};
    tv[8]  = '{1, 1, 4'h0, 4'd3,  32'hFFFFFFFF, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 1, 0};
    tv[9]  = '{1, 0, 4'h0, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 1, 1};
    tv[10] = '{0, 1, 4'hF, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0, 0, 0};
    tv[11] = '{1, 0, 4'h0, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 1, 1};
    tv[12] = '{1, 1, 4'h8, 4'd15, 32'hDEADBEEF, 32'h00000000, 32'hDE000000, 32'hAA22CC44, 1, 1, 0};
    tv[13] = '{1, 0, 4'h0, 4'd15, 32'h00000000, 32'hDE000000, 32'hDE000000, 32'hDE000000, 1, 1, 1};
    reset = 1'b1;
    ce = 1'b0;
    we = 1'b0;
    be = 4'h0;
    addr = 4'd0;
    data = 32'h0;
    step();
    step();
    chk("reset data", d0, 32'h0);
    chk("reset valid", {v0, v1, v2}, 3'b000);
    chk("reset busy", {bz0, bz1, bz2}, 3'b111);
    reset = 1'b0;
    ce = 1'b1;
    addr = 4'd5;
    busy_window("clear");
    step();
    if (LAT == 2) step();
    chk("first read valid", v0, 1'b1);
    chk("first read data", d0, 32'h0);
    for (int i = 0; i < 14; i++) begin
      ce = tv[i].ce;
      we = tv[i].we;
      be = tv[i].be;
      addr = tv[i].addr;
      data = tv[i].data;
      step();
      ce = 1'b0;
      we = 1'b0;
      if (LAT == 2) step();
      chk($sformatf("vec%0d d0", i), d0, tv[i].e0);
      chk($sformatf("vec%0d d1", i), d1, tv[i].e1);
      chk($sformatf("vec%0d d2", i), d2, tv[i].e2);
      chk($sformatf("vec%0d v0", i), v0, tv[i].ev0);
      chk($sformatf("vec%0d v1", i), v1, tv[i].ev1);
      chk($sformatf("vec%0d v2", i), v2, tv[i].ev2);
    end
    stream(1'b1, 1'b0);
    stream(1'b0, 1'b0);
    ce = 1'b1;
    we = 1'b1;
    be = 4'hF;
    addr = 4'd2;
    data = 32'hFFFFFFFF;
    reset = 1'b1;
    step();
    chk("ready reset busy", {bz0, bz1, bz2}, 3'b111);
    chk("ready reset valid", {v0, v1, v2}, 3'b000);
    chk("ready reset data", d0, 32'h0);
    reset = 1'b0;
    ce = 1'b0;
    we = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("mid clear busy", bz0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy_window("reclear");
    stream(1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port synchronous RAM with per-byte write enables, a selectable read-during-write mode, and a hardware clear sequencer that zeroes every location after reset. Accesses are accepted only when `i_ce` is high and the clear sequence has finished. Read data is registered and qualified by `o_valid`. It is the general-purpose on-chip storage block for buffers and register files; it replaces fixed 64x8 single-port arrays.

## Interface
- `DATA_W`, default 32: word width in bits.
  - Must be a multiple of 8.
- `ADDR_W`, default 6: address width.
  - DEPTH = 2**ADDR_W.
- `RW_MODE`, default 0: read-during-write behaviour.
  - 0 = read-first.
  - 1 = write-first.
  - 2 = no-change.
- `i_clk` input 1: single clock. All logic is on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_ce` input 1: access request, sampled each cycle.
- `i_we` input 1: write qualifier. Meaningful only with `i_ce`.
- `i_be` input DATA_W/8: byte write enables. Bit b covers data[8b+7:8b].
- `i_addr` input ADDR_W: word address.
- `i_data` input DATA_W: write data.
- `o_data` output DATA_W: registered read data.
- `o_valid` output 1: one-cycle pulse marking `o_data` as new.
- `o_busy` output 1: high while the clear sequence runs. Accesses are ignored while it is high.

## Operation
- FSM with two states: CLEAR and READY.
- **Reset (`i_reset`=1):**
  - state <= CLEAR, clear pointer <= 0.
  - `o_data` <= 0, `o_valid` <= 0, `o_busy` <= 1.
  - No memory write occurs while reset is high.
- **CLEAR:**
  - Each cycle writes all-zero to mem[clear pointer], then increments the pointer.
  - On the cycle that writes address DEPTH-1, state <= READY and `o_busy` <= 0.
  - `i_ce` is ignored: no write, no `o_valid`.
- **READY, accepted access (`i_ce`=1):**
  - **Read (`i_we`=0):** `o_data` <= mem[i_addr], `o_valid` <= 1.
  - **Write (`i_we`=1):** for each b with `i_be[b]`=1, byte b of mem[i_addr] <= byte b of `i_data`.
  - Write with `i_be`=0 leaves memory unchanged but is still treated as a write for the output rules below.
  - Output on a write, by RW_MODE:
    - 0: `o_data` <= the word before the write; `o_valid` <= 1.
    - 1: `o_data` <= the byte-merged new word; `o_valid` <= 1.
    - 2: `o_data` holds its value; `o_valid` <= 0.
- **READY, `i_ce`=0:** memory unchanged, `o_data` holds, `o_valid` <= 0.
- One access per cycle with no stalls. Back-to-back accesses to the same address see the previous write.
- Address arithmetic is unsigned modulo DEPTH.

## Timing
- Read latency is 1 cycle: an access on edge N gives `o_data`/`o_valid` after edge N.
- `o_busy` is high from the reset cycle through DEPTH cycles after reset deasserts.
  - The first accepted access is on cycle DEPTH+1 after reset falls.
- **Reset during CLEAR:** the clear pointer restarts at 0 and the full DEPTH-cycle clear is repeated.
- **Reset in READY:** contents are re-cleared, and any access presented in the reset cycle is dropped.
- `o_valid` is never high while `o_busy` is high.
  - Exception: when SPRAM_OUTREG_EN is defined, the second stage drains.

## Configuration
- Macro `SPRAM_OUTREG_EN`, when defined, adds a second output register stage.
  - Read latency becomes 2 cycles.
  - `o_valid` is delayed identically.
  - Both stages reset to 0.
  - Throughput stays at 1 access per cycle.
  - In RW_MODE 2, the stage-2 `o_data` holds when its stage-1 input was not valid.
- Undefined: single output register with 1-cycle latency, as described above.

## Test plan
- **Clear sequence** (DATA_W=32, ADDR_W=4):
  - Stimulus: assert reset 2 cycles, release, hold `i_ce`=1 reading addr 5.
  - Required: `o_busy`=1 for 16 cycles after release and no `o_valid` during that time; the first read returns 0x00000000 with `o_valid`=1.
- **Byte enables:**
  - Stimulus: write 0xAABBCCDD to addr 3 with `i_be`=4'b1111, then 0x11223344 with `i_be`=4'b0101, then read addr 3.
  - Required: read returns 0xAA22CC44.
- **RW_MODE 0 vs 1 vs 2:**
  - Stimulus: with mem[7]=0x12345678, write 0xCAFEF00D to addr 7 with all enables.
  - Required `o_data` in the same-latency cycle:
    - mode 0: 0x12345678, `o_valid`=1.
    - mode 1: 0xCAFEF00D, `o_valid`=1.
    - mode 2: previous `o_data` held, `o_valid`=0.
- **Reset mid-clear:**
  - Stimulus: assert reset at clear pointer 9, hold 1 cycle.
  - Required: `o_busy` remains high for a further full 16 cycles; all 16 locations then read 0.
- **Streaming:**
  - Stimulus: write addr 0..15 with value addr*0x01010101, then read 0..15 back-to-back.
  - Required: 16 consecutive `o_valid` pulses with matching data.
  - With SPRAM_OUTREG_EN defined, each response arrives exactly one cycle later.
- **Idle cycles:**
  - Stimulus: `i_ce`=0 between two reads.
  - Required: `o_valid`=0 and `o_data` holds the last read value.
